// File: rtl/operand_seq_pkg.sv
// Shared types, control encodings and opcode decode for the operand sequencer.
// ELPM_EN enables decoding of ELPM Rd,Z / Rd,Z+.
package operand_seq_pkg;

    typedef enum logic [1:0] {StIdle, StE1, StE2, StE3} state_e;

    typedef enum logic [2:0] {
        ClsNone, ClsAdiw, ClsLdSt, ClsLdd, ClsPush, ClsPop, ClsLpm
    } cls_e;

    typedef enum logic [1:0] {ModePlain, ModeInc, ModeDec} mode_e;

    localparam logic [1:0] RamNone    = 2'b00;
    localparam logic [1:0] RamLoad    = 2'b01;
    localparam logic [1:0] RamStore   = 2'b10;

    localparam logic [2:0] AddrInst   = 3'd0;
    localparam logic [2:0] AddrPtr    = 3'd1;
    localparam logic [2:0] AddrSp     = 3'd2;
    localparam logic [2:0] AddrPtrImm = 3'd3;

    localparam logic [1:0] PtrX       = 2'b00;
    localparam logic [1:0] PtrY       = 2'b01;
    localparam logic [1:0] PtrZ       = 2'b10;

    localparam logic [2:0] ImmNone    = 3'd0;
    localparam logic [2:0] ImmK6      = 3'd1;
    localparam logic [2:0] ImmQ6      = 3'd2;

    localparam logic [1:0] OpHold     = 2'b00;
    localparam logic [1:0] OpInc      = 2'b01;
    localparam logic [1:0] OpDec      = 2'b10;

    localparam logic [15:0] MaskAdiw  = 16'hFE00;  // ADIW 0x96xx, SBIW 0x97xx
    localparam logic [15:0] OpAdiw    = 16'h9600;
    localparam logic [15:0] MaskLdd   = 16'hD000;  // LDD/STD Y/Z+q, bit9 store, bit3 Y
    localparam logic [15:0] OpLdd     = 16'h8000;
    localparam logic [15:0] MaskLdSt  = 16'hFC00;  // 0x90xx-0x93xx, bit9 store
    localparam logic [15:0] OpLdSt    = 16'h9000;

    typedef struct packed {
        cls_e       cls;
        logic [1:0] ptr;
        mode_e      mode;
        logic       is_store;
        logic       is_elpm;
        logic       legal;
    } dec_t;

    function automatic dec_t decode_inst(input logic [15:0] inst);
        dec_t d;
        d.cls      = ClsNone;
        d.ptr      = PtrX;
        d.mode     = ModePlain;
        d.is_store = inst[9];
        d.is_elpm  = 1'b0;
        if ((inst & MaskAdiw) == OpAdiw) begin
            d.cls      = ClsAdiw;
            d.is_store = 1'b0;
        end else if ((inst & MaskLdd) == OpLdd) begin
            d.cls = ClsLdd;
            d.ptr = inst[3] ? PtrY : PtrZ;
        end else if ((inst & MaskLdSt) == OpLdSt) begin
            case (inst[3:0])
                4'h1: begin d.cls = ClsLdSt; d.ptr = PtrZ; d.mode = ModeInc; end
                4'h2: begin d.cls = ClsLdSt; d.ptr = PtrZ; d.mode = ModeDec; end
                4'h9: begin d.cls = ClsLdSt; d.ptr = PtrY; d.mode = ModeInc; end
                4'hA: begin d.cls = ClsLdSt; d.ptr = PtrY; d.mode = ModeDec; end
                4'hC: begin d.cls = ClsLdSt; d.ptr = PtrX; end
                4'hD: begin d.cls = ClsLdSt; d.ptr = PtrX; d.mode = ModeInc; end
                4'hE: begin d.cls = ClsLdSt; d.ptr = PtrX; d.mode = ModeDec; end
                4'h4, 4'h5: begin
                    if (!inst[9]) begin
                        d.cls  = ClsLpm;
                        d.ptr  = PtrZ;
                        d.mode = inst[0] ? ModeInc : ModePlain;
                    end
                end
`ifdef ELPM_EN
                4'h6, 4'h7: begin
                    if (!inst[9]) begin
                        d.cls     = ClsLpm;
                        d.ptr     = PtrZ;
                        d.mode    = inst[0] ? ModeInc : ModePlain;
                        d.is_elpm = 1'b1;
                    end
                end
`endif
                4'hF: d.cls = inst[9] ? ClsPush : ClsPop;
                default: d.cls = ClsNone;
            endcase
        end
        d.legal = (d.cls != ClsNone);
        return d;
    endfunction

    function automatic logic inst_legal(input logic [15:0] inst);
        dec_t d;
        d = decode_inst(inst);
        return d.legal;
    endfunction

endpackage

// File: rtl/operand_seq_decode.sv
// Combinational decode of the latched instruction into class, pointer and addressing mode.
module operand_seq_decode
    import operand_seq_pkg::*;
(
    input  logic [15:0] inst_i,
    output dec_t        dec_o
);

    assign dec_o = decode_inst(inst_i);

endmodule

// File: rtl/operand_seq.sv
// Multi-cycle sequencer for memory-class instructions; drives operand datapath controls.
// ELPM_EN enables ELPM decode and the RAMPZ increment strobe.
module operand_seq
    import operand_seq_pkg::*;
#(
    parameter int unsigned PTR_W    = 16,
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [15:0]      inst_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic             mem_wait_i,
    input  logic             flush_i,
    input  logic [PTR_W-1:0] z_i,
    output logic [15:0]      ir_o,
    output logic             busy_o,
    output logic             illegal_op_o,
    output logic             c_rd_rr_sel_o,
    output logic             c_adiw_phase_o,
    output logic             c_rd_w_en_o,
    output logic [1:0]       c_ram_op_o,
    output logic [2:0]       c_ram_addr_sel_o,
    output logic [1:0]       c_rh_sel_o,
    output logic [2:0]       c_imm_type_o,
    output logic             c_rampz_inc_o,
    output logic [1:0]       c_sp_op_o,
    output logic [1:0]       c_rh_op_o,
    output logic             c_prog_rd_o
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    dec_t        dec;
    logic [1:0]  ncyc;
    logic        last, accept;

    logic       w_en, rampz;
    logic [1:0] sp_op, rh_op;

    operand_seq_decode u_decode (
        .inst_i (ir_q),
        .dec_o  (dec)
    );

    always_comb begin
        case (dec.cls)
            ClsLdSt:         ncyc = (!dec.is_store && dec.mode == ModeDec) ? 2'd3 : 2'd2;
            ClsLdd:          ncyc = dec.is_store ? 2'd1 : 2'd2;
            ClsPop:          ncyc = 2'd3;
            ClsAdiw, ClsLpm: ncyc = 2'd2;
            default:         ncyc = 2'd1;
        endcase
    end

    assign last = (state_q == StE1 && ncyc == 2'd1) ||
                  (state_q == StE2 && ncyc == 2'd2) ||
                  (state_q == StE3);

    assign inst_ready_o = (state_q == StIdle) && !flush_i;
    assign accept       = inst_ready_o && inst_valid_i && inst_legal(inst_i);
    assign illegal_d    = inst_ready_o && inst_valid_i && !inst_legal(inst_i);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (flush_i) begin
            state_d = StIdle;
            ir_d    = IR_RESET;
        end else if (state_q == StIdle) begin
            if (accept) begin
                state_d = StE1;
                ir_d    = inst_i;
            end
        end else if (!mem_wait_i) begin
            case (state_q)
                StE1:    state_d = last ? StIdle : StE2;
                StE2:    state_d = last ? StIdle : StE3;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ir_q      <= IR_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Controls depend only on state and ir; side-effect strobes are masked below.
    always_comb begin
        c_rd_rr_sel_o    = 1'b0;
        c_adiw_phase_o   = 1'b0;
        w_en             = 1'b0;
        c_ram_op_o       = RamNone;
        c_ram_addr_sel_o = AddrInst;
        c_rh_sel_o       = PtrX;
        c_imm_type_o     = ImmNone;
        rampz            = 1'b0;
        sp_op            = OpHold;
        rh_op            = OpHold;
        c_prog_rd_o      = 1'b0;
        if (state_q != StIdle) begin
            c_rd_rr_sel_o = (dec.cls != ClsAdiw);
            c_rh_sel_o    = dec.ptr;
            case (dec.cls)
                ClsAdiw: begin
                    w_en = 1'b1;
                    if (state_q == StE1) c_imm_type_o = ImmK6;
                    else                 c_adiw_phase_o = 1'b1;
                end
                ClsLdSt: begin
                    if (dec.mode == ModeDec) begin
                        if (state_q == StE1) begin
                            rh_op = OpDec;
                        end else if (state_q == StE2) begin
                            c_ram_op_o       = dec.is_store ? RamStore : RamLoad;
                            c_ram_addr_sel_o = AddrPtr;
                        end else begin
                            w_en = 1'b1;
                        end
                    end else if (state_q == StE1) begin
                        c_ram_op_o       = dec.is_store ? RamStore : RamLoad;
                        c_ram_addr_sel_o = AddrPtr;
                    end else begin
                        w_en = !dec.is_store;
                        if (dec.mode == ModeInc) rh_op = OpInc;
                    end
                end
                ClsLdd: begin
                    if (state_q == StE1) begin
                        c_ram_op_o       = dec.is_store ? RamStore : RamLoad;
                        c_ram_addr_sel_o = AddrPtrImm;
                        c_imm_type_o     = ImmQ6;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                ClsPush: begin
                    c_ram_op_o       = RamStore;
                    c_ram_addr_sel_o = AddrSp;
                    sp_op            = OpDec;
                end
                ClsPop: begin
                    if (state_q == StE1) begin
                        sp_op = OpInc;
                    end else if (state_q == StE2) begin
                        c_ram_op_o       = RamLoad;
                        c_ram_addr_sel_o = AddrSp;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                ClsLpm: begin
                    if (state_q == StE1) begin
                        c_prog_rd_o = 1'b1;
                    end else begin
                        w_en = 1'b1;
                        if (dec.mode == ModeInc) rh_op = OpInc;
`ifdef ELPM_EN
                        rampz = dec.is_elpm && (dec.mode == ModeInc) &&
                                (z_i == {PTR_W{1'b1}});
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign c_rd_w_en_o   = w_en  & ~mem_wait_i;
    assign c_rampz_inc_o = rampz & ~mem_wait_i;
    assign c_sp_op_o     = mem_wait_i ? OpHold : sp_op;
    assign c_rh_op_o     = mem_wait_i ? OpHold : rh_op;

    assign ir_o         = ir_q;
    assign busy_o       = (state_q != StIdle);
    assign illegal_op_o = illegal_q;

    logic unused_dec;
    assign unused_dec = dec.legal ^ dec.is_elpm;
`ifndef ELPM_EN
    logic unused_z;
    assign unused_z = ^z_i;
`endif

endmodule

// File: tb/tb_operand_seq.sv
// Scoreboard bench for operand_seq: per-cycle expected controls queued at issue, popped per cycle.
module tb_operand_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] inst_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic        mem_wait_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [15:0] z_i = '0;
    logic [15:0] ir_o;
    logic        busy_o, illegal_op_o;
    logic        c_rd_rr_sel_o, c_adiw_phase_o, c_rd_w_en_o;
    logic [1:0]  c_ram_op_o;
    logic [2:0]  c_ram_addr_sel_o;
    logic [1:0]  c_rh_sel_o;
    logic [2:0]  c_imm_type_o;
    logic        c_rampz_inc_o;
    logic [1:0]  c_sp_op_o, c_rh_op_o;
    logic        c_prog_rd_o;

    operand_seq dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .inst_i           (inst_i),
        .inst_valid_i     (inst_valid_i),
        .inst_ready_o     (inst_ready_o),
        .mem_wait_i       (mem_wait_i),
        .flush_i          (flush_i),
        .z_i              (z_i),
        .ir_o             (ir_o),
        .busy_o           (busy_o),
        .illegal_op_o     (illegal_op_o),
        .c_rd_rr_sel_o    (c_rd_rr_sel_o),
        .c_adiw_phase_o   (c_adiw_phase_o),
        .c_rd_w_en_o      (c_rd_w_en_o),
        .c_ram_op_o       (c_ram_op_o),
        .c_ram_addr_sel_o (c_ram_addr_sel_o),
        .c_rh_sel_o       (c_rh_sel_o),
        .c_imm_type_o     (c_imm_type_o),
        .c_rampz_inc_o    (c_rampz_inc_o),
        .c_sp_op_o        (c_sp_op_o),
        .c_rh_op_o        (c_rh_op_o),
        .c_prog_rd_o      (c_prog_rd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rr;
        logic       ph;
        logic       we;
        logic [1:0] ram;
        logic [2:0] asel;
        logic [1:0] rh;
        logic [2:0] imm;
        logic       rz;
        logic [1:0] sp;
        logic [1:0] rhop;
        logic       pr;
    } ctl_t;

    typedef struct packed {
        logic mw;
        logic fl;
        ctl_t ctl;
    } ent_t;

    ent_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ctl_t mk(input logic rr, input logic ph, input logic we,
                                input logic [1:0] ram, input logic [2:0] asel,
                                input logic [1:0] rh, input logic [2:0] imm, input logic rz,
                                input logic [1:0] sp, input logic [1:0] rhop, input logic pr);
        ctl_t c;
        c = '{rr, ph, we, ram, asel, rh, imm, rz, sp, rhop, pr};
        return c;
    endfunction

    function automatic ctl_t obs();
        ctl_t c;
        c = '{c_rd_rr_sel_o, c_adiw_phase_o, c_rd_w_en_o, c_ram_op_o, c_ram_addr_sel_o,
              c_rh_sel_o, c_imm_type_o, c_rampz_inc_o, c_sp_op_o, c_rh_op_o, c_prog_rd_o};
        return c;
    endfunction

    task automatic push(input logic mw, input logic fl, input ctl_t c);
        exp_q.push_back({mw, fl, c});
    endtask

    // Hands one word over; returns at the falling edge of the first cycle after the handshake.
    task automatic send(input logic [15:0] w, input string tag);
        @(negedge clk_i);
        check_eq({tag, "_ready"}, 32'(inst_ready_o), 32'd1);
        inst_i       = w;
        inst_valid_i = 1'b1;
        @(negedge clk_i);
        inst_valid_i = 1'b0;
        inst_i       = 16'h0000;
    endtask

    task automatic drain(input string tag);
        int   n;
        ent_t e;
        n = 0;
        while (exp_q.size() > 0) begin
            if (n >= 20) begin
                check_eq({tag, "_timeout"}, 32'(n), 32'd0);
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            mem_wait_i = e.mw;
            flush_i    = e.fl;
            #1;
            check_eq({tag, "_ctl"}, 32'(obs()), 32'(e.ctl));
            check_eq({tag, "_busy_ready"}, 32'({busy_o, inst_ready_o}), 32'b10);
            @(negedge clk_i);
            n++;
        end
        mem_wait_i = 1'b0;
        flush_i    = 1'b0;
        #1;
        check_eq({tag, "_end"}, 32'({busy_o, inst_ready_o, illegal_op_o}), 32'b010);
        check_eq({tag, "_endctl"}, 32'(obs()), 32'd0);
    endtask

    task automatic expect_illegal(input logic [15:0] w, input string tag);
        send(w, tag);
        #1;
        check_eq({tag, "_pulse"}, 32'({illegal_op_o, busy_o}), 32'b10);
        check_eq({tag, "_ctl"}, 32'(obs()), 32'd0);
        @(negedge clk_i);
        #1;
        check_eq({tag, "_pulse_end"}, 32'({illegal_op_o, busy_o}), 32'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        check_eq("rst_ctl", 32'(obs()), 32'd0);
        check_eq("rst_status", 32'({busy_o, illegal_op_o}), 32'd0);
        check_eq("rst_ir", 32'(ir_o), 32'h0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_eq("rst_ready", 32'(inst_ready_o), 32'd1);

        // ADIW R24,1 and SBIW: K6 on the low-byte cycle, phase1 on the second
        send(16'h9601, "adiw");
        check_eq("adiw_ir", 32'(ir_o), 32'h9601);
        push(0, 0, mk(0, 0, 1, 2'b00, 3'd0, 2'b00, 3'd1, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(0, 1, 1, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("adiw");
        send(16'h9701, "sbiw");
        push(0, 0, mk(0, 0, 1, 2'b00, 3'd0, 2'b00, 3'd1, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(0, 1, 1, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("sbiw");

        // LD R16,-X
        send(16'h910E, "ld_predec");
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b10, 0));
        push(0, 0, mk(1, 0, 0, 2'b01, 3'd1, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(1, 0, 1, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("ld_predec");

        // ST Y+,R5
        send(16'h9259, "st_postinc");
        push(0, 0, mk(1, 0, 0, 2'b10, 3'd1, 2'b01, 3'd0, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b01, 3'd0, 0, 2'b00, 2'b01, 0));
        drain("st_postinc");

        // ST X,R0: second cycle idle
        send(16'h920C, "st_plain");
        push(0, 0, mk(1, 0, 0, 2'b10, 3'd1, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("st_plain");

        // LDD R16,Y+2
        send(16'h810A, "ldd");
        push(0, 0, mk(1, 0, 0, 2'b01, 3'd3, 2'b01, 3'd2, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(1, 0, 1, 2'b00, 3'd0, 2'b01, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("ldd");

        // STD Z+1,R0: single cycle
        send(16'h8201, "std");
        push(0, 0, mk(1, 0, 0, 2'b10, 3'd3, 2'b10, 3'd2, 0, 2'b00, 2'b00, 0));
        drain("std");

        // PUSH R1
        send(16'h921F, "push");
        push(0, 0, mk(1, 0, 0, 2'b10, 3'd2, 2'b00, 3'd0, 0, 2'b10, 2'b00, 0));
        drain("push");

        // POP R0 with three wait cycles in E2 and one in E3
        send(16'h900F, "pop_wait");
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b01, 2'b00, 0));
        for (int i = 0; i < 4; i++) begin
            push(i < 3, 0, mk(1, 0, 0, 2'b01, 3'd2, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        end
        push(1, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(1, 0, 1, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("pop_wait");

        // LPM R0,Z+
        z_i = 16'hFFFF;
        send(16'h9005, "lpm");
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b10, 3'd0, 0, 2'b00, 2'b00, 1));
        push(0, 0, mk(1, 0, 1, 2'b00, 3'd0, 2'b10, 3'd0, 0, 2'b00, 2'b01, 0));
        drain("lpm");

`ifdef ELPM_EN
        // ELPM R0,Z+ at Z wrap: RAMPZ strobe once, held off while waiting
        send(16'h9007, "elpm");
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b10, 3'd0, 0, 2'b00, 2'b00, 1));
        push(1, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b10, 3'd0, 0, 2'b00, 2'b00, 0));
        push(0, 0, mk(1, 0, 1, 2'b00, 3'd0, 2'b10, 3'd0, 1, 2'b00, 2'b01, 0));
        drain("elpm");
        z_i = 16'h1234;
        send(16'h9007, "elpm_nowrap");
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b10, 3'd0, 0, 2'b00, 2'b00, 1));
        push(0, 0, mk(1, 0, 1, 2'b00, 3'd0, 2'b10, 3'd0, 0, 2'b00, 2'b01, 0));
        drain("elpm_nowrap");
`else
        expect_illegal(16'h9007, "elpm_off");
`endif

        // Flush in E2 of LD -X: E2 controls still issue, then idle with ir cleared
        send(16'h910E, "flush");
        push(0, 0, mk(1, 0, 0, 2'b00, 3'd0, 2'b00, 3'd0, 0, 2'b00, 2'b10, 0));
        push(0, 1, mk(1, 0, 0, 2'b01, 3'd1, 2'b00, 3'd0, 0, 2'b00, 2'b00, 0));
        drain("flush");
        check_eq("flush_ir", 32'(ir_o), 32'h0000);

        // Reset asserted in E1: immediate idle, nothing resumes after release
        send(16'h910E, "rst_mid");
        #1;
        check_eq("rst_mid_e1", 32'(c_rh_op_o), 32'b10);
        rst_ni = 1'b0;
        #1;
        check_eq("rst_mid_ctl", 32'(obs()), 32'd0);
        check_eq("rst_mid_status", 32'({busy_o, ir_o}), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drain("rst_mid");

        // 0x0000 (NOP) is rejected
        expect_illegal(16'h0000, "nop");

        // Back-to-back after an illegal word still works
        send(16'h921F, "push2");
        push(0, 0, mk(1, 0, 0, 2'b10, 3'd2, 2'b00, 3'd0, 0, 2'b10, 2'b00, 0));
        drain("push2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
